priority_encoder_8to3: RTL and testbench
========================================

# priority_encoder_8to3

Registered 8-to-3 priority encoder. The block samples an 8-bit request vector every clock and outputs the index of the highest-numbered asserted bit, with a valid flag. It serves as a general-purpose request/interrupt index generator wherever a single winning line must be selected from eight. Bit 7 has the highest priority and bit 0 the lowest.

## Interface
- No parameters. Input width is fixed at 8 and code width at 3.
- clk   input   1   Single clock. All state updates on the rising edge.
- rst_n   input   1   Reset. Asynchronous, active-low.
- din   input   8   Request vector. Bit i set means line i is requesting.
- code   output   3   Registered index of the highest set bit of din.
- valid   output   1   Registered flag. 1 when the sampled din had at least one bit set.

## Operation
- Encoding rule: code = the largest i such that din[i] = 1. Lower bits are don't-care once a higher bit is set.
  - din[7]=1 -> 3'b111
  - din[7:6]=01 -> 3'b110
  - din[7:5]=001 -> 3'b101
  - din[7:4]=0001 -> 3'b100
  - din[7:3]=00001 -> 3'b011
  - din[7:2]=000001 -> 3'b010
  - din[7:1]=0000001 -> 3'b001
  - din=8'b00000001 -> 3'b000
- Zero input: din = 8'h00 -> code = 3'b000, valid = 0.
  - code = 000 alone is ambiguous, so consumers must qualify code with valid.
- valid = |din, sampled at the same edge as code.
- The logic is purely combinational priority resolution followed by an output register. There is no state machine and no history dependence: each cycle's output depends only on the din sampled at that edge.
- X or Z on din does not need to be resolved. Stimulus must drive din to known values.

## Timing
- Latency is 1 cycle: din present before rising edge N appears on code/valid after edge N.
- Outputs hold their values between edges. Changes to din between edges have no effect until the next edge.
- Reset assertion (rst_n falling) asynchronously forces code = 3'b000 and valid = 0 immediately, independent of clk.
- While rst_n = 0, outputs stay at the reset values and din is ignored.
- Reset release is synchronous to clk in effect: the first rising edge with rst_n = 1 samples din normally.
  - The integrating design must meet recovery/removal timing on rst_n release.
- Reset asserted mid-operation discards the pending sample. There is no recovery of the previous output.
- There is no handshake or back-pressure. A new result is produced every cycle (throughput 1/cycle).

## Test plan
- Reset:
  - Drive din = 8'hFF and assert rst_n = 0 between clock edges -> code = 000 and valid = 0 immediately, without waiting for a clock edge.
  - Release rst_n; the next edge gives code = 111, valid = 1.
- Priority with lower bits set. Apply one value per cycle, each checked one cycle later:
  - din = 10010011 -> 111
  - din = 01001000 -> 110
  - din = 00110100 -> 101
  - din = 00011000 -> 100
- One-hot sweep: din = 10000000, 01000000, 00100000, 00010000, 00001000, 00000100, 00000010, 00000001 -> code = 111, 110, 101, 100, 011, 010, 001, 000, each with valid = 1.
- Zero vs. bit 0:
  - din = 00000000 -> code = 000, valid = 0.
  - Next cycle din = 00000001 -> code = 000, valid = 1.
- Latency and hold:
  - Change din mid-cycle from 00010000 to 10000000 -> code stays 100 until the next edge, then becomes 111.
  - Check that code never updates between edges.
- Exhaustive: all 256 din values against a reference model -> code and valid match, one cycle delayed.

Source files
------------

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder: index of the highest set request bit plus a valid flag.
// Bit 7 wins over all lower bits; an all-zero request yields code 0 with valid low.

module priority_encoder_8to3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    output logic [2:0] code,
    output logic       valid
);

    logic [2:0] code_d;
    logic       valid_d;

    // Ascending scan so the highest set bit is the last assignment and wins.
    always_comb begin
        code_d = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (din[i]) begin
                code_d = 3'(i);
            end
        end
        valid_d = |din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code  <= 3'b000;
            valid <= 1'b0;
        end else begin
            code  <= code_d;
            valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Scoreboarded bench for priority_encoder_8to3: a driver queues expected results from a
// log2-based reference model, and a monitor compares them one cycle later.

module tb_priority_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [2:0] code;
    logic       valid;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [3:0] exp_q[$];  // {valid, code}

    priority_encoder_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .code  (code),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set bit of a nonzero value is floor(log2(v)) = clog2(v+1)-1.
    function automatic logic [3:0] model(input logic [7:0] v);
        int idx;
        if (v == 8'h00) return 4'b0_000;
        idx = $clog2(int'(v) + 1) - 1;
        return {1'b1, 3'(idx)};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got valid=%b code=%b, expected valid=%b code=%b (t=%0t)",
                     name, act[3], act[2:0], exp[3], exp[2:0], $time);
        end
    endtask

    // Drive one request vector on the falling edge and queue its expected result.
    task automatic apply(input logic [7:0] v);
        @(negedge clk);
        din = v;
        exp_q.push_back(model(v));
    endtask

    // Monitor: the DUT presents a fresh result after every rising edge.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {valid, code}, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] dir_vals[4];
        int         wait_cycles;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        din   = 8'h00;

        repeat (3) @(posedge clk);
        #1 check("reset_state", {valid, code}, 4'b0_000);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset with din = FF: outputs were 111/1, must clear without a clock.
        @(negedge clk);
        din = 8'hFF;
        @(posedge clk);
        #1 check("pre_reset_ff", {valid, code}, model(8'hFF));
        #2 rst_n = 1'b0;
        #1 check("async_reset", {valid, code}, 4'b0_000);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", {valid, code}, 4'b0_000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(din));

        // Priority with lower bits set.
        dir_vals[0] = 8'b1001_0011;
        dir_vals[1] = 8'b0100_1000;
        dir_vals[2] = 8'b0011_0100;
        dir_vals[3] = 8'b0001_1000;
        foreach (dir_vals[i]) apply(dir_vals[i]);

        // One-hot sweep from bit 7 down to bit 0.
        for (int i = 7; i >= 0; i--) apply(8'(1 << i));

        // Zero versus bit 0.
        apply(8'h00);
        apply(8'h01);

        // Latency and hold: a mid-cycle change must not reach the outputs before the edge.
        apply(8'b0001_0000);
        @(posedge clk);
        #2 din = 8'b1000_0000;
        exp_q.push_back(model(8'b1000_0000));
        for (int k = 0; k < 3; k++) begin
            #2 check("hold_between_edges", {valid, code}, 4'b1_100);
        end

        // Exhaustive sweep.
        for (int v = 0; v < 256; v++) apply(8'(v));

        // Random stimulus.
        for (int k = 0; k < 300; k++) apply(8'($urandom_range(0, 255)));

        // Drain the scoreboard within a bounded number of cycles.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
